// File: rtl/sram_loader_pkg.sv
// sram_loader_pkg
// Shared defaults and the loader state enumeration.
// Contents:
//   DEF_ADDR_W  default SRAM address width
//   DEF_DATA_W  default SRAM word width
//   state_t     loader FSM states
//   pick_next   picks the first non-empty phase, otherwise a fallback state
package sram_loader_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD1,
        LOAD2,
        TRAILER,
        RB1,
        RB2,
        FINISH
    } state_t;

    // Zero-count regions are skipped entirely, so every phase hand-off goes
    // through this priority pick.
    function automatic state_t pick_next(input logic take_a, input state_t a,
                                         input logic take_b, input state_t b,
                                         input state_t fallback);
        if (take_a) return a;
        if (take_b) return b;
        return fallback;
    endfunction

endpackage

// File: rtl/sram_loader_if.sv
// sram_loader_if
// Word stream plus the two SRAM ports (image RAM = src1, weight RAM = src2).
// Signals:
//   in_valid, in_data, in_ready               valid/ready word stream
//   srcN_address, srcN_writedata, srcN_write_en  RAM write/read request
//   srcN_readdata                             RAM read data, one-cycle latency
// Modports:
//   master  environment side (stream source and RAMs)
//   slave   loader side
interface sram_loader_if
    import sram_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    logic [ADDR_W-1:0] src1_address;
    logic [DATA_W-1:0] src1_writedata;
    logic              src1_write_en;
    logic [DATA_W-1:0] src1_readdata;

    logic [ADDR_W-1:0] src2_address;
    logic [DATA_W-1:0] src2_writedata;
    logic              src2_write_en;
    logic [DATA_W-1:0] src2_readdata;

    modport master (
        output in_valid, in_data, src1_readdata, src2_readdata,
        input  in_ready,
        input  src1_address, src1_writedata, src1_write_en,
        input  src2_address, src2_writedata, src2_write_en
    );

    modport slave (
        input  in_valid, in_data, src1_readdata, src2_readdata,
        output in_ready,
        output src1_address, src1_writedata, src1_write_en,
        output src2_address, src2_writedata, src2_write_en
    );

endinterface

// File: rtl/sram_loader_region_walker.sv
// sram_loader_region_walker
// Walks one RAM region: the address counts up from the start address (wrapping
// at 2^ADDR_W) while a down-counter tracks the words still to go.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   load           latch start_address / count
//   step           advance one word
//   start_address  first address of the region
//   count          number of words in the region
//   address        current word address (registered)
//   last           current word is the final one of the region
module sram_loader_region_walker
    import sram_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] address,
    output logic              last
);

    logic [ADDR_W:0] remaining;

    always_ff @(posedge clk) begin
        if (reset) begin
            address   <= '0;
            remaining <= '0;
        end else if (load) begin
            address   <= start_address;
            remaining <= count;
        end else if (step) begin
            address   <= address + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
        end
    end

    assign last = (remaining == (ADDR_W+1)'(1));

endmodule

// File: rtl/sram_loader.sv
// sram_loader
// Loads an image region and a weight region from a word stream into two SRAMs,
// takes a trailing checksum word, reads both regions back and flags a mismatch.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      one-cycle load request, honoured only in IDLE
//   src1/src2_start_address    first write address of each region
//   src1/src2_count            words per region (0..2^ADDR_W)
//   bus                        word stream and both RAM ports (slave side)
//   busy                       high outside IDLE
//   done                       one-cycle completion pulse
//   error                      checksum mismatch, held until the next start
//   layer_start                one-cycle pulse with done when error is low
//
// state   | meaning
// IDLE    | waiting for start
// LOAD1   | writing stream words into the image RAM
// LOAD2   | writing stream words into the weight RAM
// TRAILER | capturing the expected checksum word
// RB1     | reading back the image region, then one drain cycle
// RB2     | reading back the weight region, then one drain cycle
// FINISH  | comparing sums, issuing done / layer_start
module sram_loader
    import sram_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src1_start_address,
    input  logic [ADDR_W-1:0] src2_start_address,
    input  logic [ADDR_W:0]   src1_count,
    input  logic [ADDR_W:0]   src2_count,
    sram_loader_if.slave      bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              layer_start
);

    state_t            state;
    logic [ADDR_W-1:0] start1_q, start2_q;
    logic [ADDR_W:0]   count1_q, count2_q;
    logic [DATA_W-1:0] run_sum, rb_sum, trailer_q;
    logic              rd_pend;  // an address was issued last cycle, its data is on readdata now
    logic              drain;    // all addresses of the region issued, waiting for the last word

    logic              xfer, mismatch, idle_start, rb_reload;
    logic              w1_load, w1_step, w1_last;
    logic              w2_load, w2_step, w2_last;
    logic [ADDR_W-1:0] w1_start, w2_start;
    logic [ADDR_W:0]   w1_count, w2_count;

    assign bus.in_ready = (state == LOAD1) || (state == LOAD2) || (state == TRAILER);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign busy         = (state != IDLE);

    assign bus.src1_write_en  = xfer && (state == LOAD1);
    assign bus.src2_write_en  = xfer && (state == LOAD2);
    assign bus.src1_writedata = bus.src1_write_en ? bus.in_data : '0;
    assign bus.src2_writedata = bus.src2_write_en ? bus.in_data : '0;

    // Both walkers are loaded from the ports when the load starts and reloaded
    // from the latched copies when readback begins.
    assign idle_start = (state == IDLE) && start;
    assign rb_reload  = (state == TRAILER) && xfer;
    assign w1_load    = idle_start || rb_reload;
    assign w2_load    = idle_start || rb_reload;
    assign w1_start   = (state == IDLE) ? src1_start_address : start1_q;
    assign w2_start   = (state == IDLE) ? src2_start_address : start2_q;
    assign w1_count   = (state == IDLE) ? src1_count : count1_q;
    assign w2_count   = (state == IDLE) ? src2_count : count2_q;
    assign w1_step    = ((state == LOAD1) && xfer) || ((state == RB1) && !drain);
    assign w2_step    = ((state == LOAD2) && xfer) || ((state == RB2) && !drain);

    assign mismatch = (rb_sum != trailer_q) || (rb_sum != run_sum);

    sram_loader_region_walker #(.ADDR_W(ADDR_W)) u_walk1 (
        .clk(clk), .reset(reset), .load(w1_load), .step(w1_step),
        .start_address(w1_start), .count(w1_count),
        .address(bus.src1_address), .last(w1_last)
    );

    sram_loader_region_walker #(.ADDR_W(ADDR_W)) u_walk2 (
        .clk(clk), .reset(reset), .load(w2_load), .step(w2_step),
        .start_address(w2_start), .count(w2_count),
        .address(bus.src2_address), .last(w2_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            start1_q    <= '0;
            start2_q    <= '0;
            count1_q    <= '0;
            count2_q    <= '0;
            run_sum     <= '0;
            rb_sum      <= '0;
            trailer_q   <= '0;
            rd_pend     <= 1'b0;
            drain       <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            layer_start <= 1'b0;
        end else begin
            done        <= 1'b0;
            layer_start <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    start1_q <= src1_start_address;
                    start2_q <= src2_start_address;
                    count1_q <= src1_count;
                    count2_q <= src2_count;
                    run_sum  <= '0;
                    rb_sum   <= '0;
                    error    <= 1'b0;
                    state    <= pick_next(src1_count != '0, LOAD1,
                                          src2_count != '0, LOAD2, TRAILER);
                end
                LOAD1: if (xfer) begin
                    run_sum <= run_sum + bus.in_data;
                    if (w1_last) state <= (count2_q != '0) ? LOAD2 : TRAILER;
                end
                LOAD2: if (xfer) begin
                    run_sum <= run_sum + bus.in_data;
                    if (w2_last) state <= TRAILER;
                end
                TRAILER: if (xfer) begin
                    trailer_q <= bus.in_data;
                    rd_pend   <= 1'b0;
                    drain     <= 1'b0;
                    state     <= pick_next(count1_q != '0, RB1,
                                           count2_q != '0, RB2, FINISH);
                end
                RB1: begin
                    if (rd_pend) rb_sum <= rb_sum + bus.src1_readdata;
                    if (drain) begin
                        rd_pend <= 1'b0;
                        drain   <= 1'b0;
                        state   <= (count2_q != '0) ? RB2 : FINISH;
                    end else begin
                        rd_pend <= 1'b1;
                        drain   <= w1_last;
                    end
                end
                RB2: begin
                    if (rd_pend) rb_sum <= rb_sum + bus.src2_readdata;
                    if (drain) begin
                        rd_pend <= 1'b0;
                        drain   <= 1'b0;
                        state   <= FINISH;
                    end else begin
                        rd_pend <= 1'b1;
                        drain   <= w2_last;
                    end
                end
                FINISH: begin
                    error       <= mismatch;
                    done        <= 1'b1;
                    layer_start <= !mismatch;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_loader.sv
// tb_sram_loader
// Scoreboarded bench: each scenario pushes its expected RAM writes and done
// flags into a queue; a monitor pops and compares on every write enable and
// every done pulse. Two behavioural RAMs with one-cycle read latency sit on
// the RAM ports.
module tb_sram_loader;

    localparam int AW = 12;
    localparam int DW = 16;

    typedef struct {
        int kind;  // 1 = src1 write, 2 = src2 write, 3 = done
        int a;     // write address, or error flag for done
        int d;     // write data, or layer_start for done
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] src1_start_address, src2_start_address;
    logic [AW:0]   src1_count, src2_count;
    logic          busy, done, error, layer_start;

    sram_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src1_start_address(src1_start_address),
        .src2_start_address(src2_start_address),
        .src1_count(src1_count), .src2_count(src2_count),
        .bus(bus),
        .busy(busy), .done(done), .error(error), .layer_start(layer_start)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem1 [4096];
    logic [DW-1:0] mem2 [4096];
    logic          corrupt_en = 1'b0;
    localparam int            CORRUPT_ADDR = 2;
    localparam logic [DW-1:0] CORRUPT_DATA = 16'h0100;

    always_ff @(posedge clk) begin
        if (bus.src1_write_en) mem1[bus.src1_address] <= bus.src1_writedata;
        if (bus.src2_write_en) mem2[bus.src2_address] <= bus.src2_writedata;
        if (corrupt_en) mem1[CORRUPT_ADDR] <= CORRUPT_DATA;
        bus.src1_readdata <= mem1[bus.src1_address];
        bus.src2_readdata <= mem2[bus.src2_address];
    end

    int            errors = 0;
    int            checks = 0;
    exp_t          sb_q[$];
    logic [DW-1:0] stream_q[$];
    logic [DW-1:0] w1_q[$];
    logic [DW-1:0] w2_q[$];
    bit            gap_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int kind, input int a, input int d);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        sb_q.push_back(e);
    endtask

    task automatic mon_event(input int kind, input int a, input int d);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d a=%0d d=%0d expected none", kind, a, d);
        end else begin
            e = sb_q.pop_front();
            check("event_kind", kind, e.kind);
            check(kind == 3 ? "done_error" : "wr_addr", a, e.a);
            check(kind == 3 ? "done_layer_start" : "wr_data", d, e.d);
        end
    endtask

    // Monitor: everything the DUT presents is sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.src1_write_en) mon_event(1, int'(bus.src1_address), int'(bus.src1_writedata));
            if (bus.src2_write_en) mon_event(2, int'(bus.src2_address), int'(bus.src2_writedata));
            if (done) mon_event(3, int'(error), int'(layer_start));
        end
    end

    // Stream source: drives just after the rising edge, pops a word once it is
    // known to be accepted at the following edge.
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (stream_q.size() != 0 && !(gap_mode && $urandom_range(0, 2) == 0)) begin
                bus.in_valid = 1'b1;
                bus.in_data  = stream_q[0];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = DW'($urandom);
            end
            if (bus.in_valid && bus.in_ready) void'(stream_q.pop_front());
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},    bus.in_ready, 0);
        check({tag, "_wr_en1"},      bus.src1_write_en, 0);
        check({tag, "_wr_en2"},      bus.src2_write_en, 0);
        check({tag, "_busy"},        busy, 0);
        check({tag, "_done"},        done, 0);
        check({tag, "_error"},       error, 0);
        check({tag, "_layer_start"}, layer_start, 0);
        check({tag, "_addr1"},       bus.src1_address, 0);
        check({tag, "_addr2"},       bus.src2_address, 0);
        check({tag, "_wdata1"},      bus.src1_writedata, 0);
        check({tag, "_wdata2"},      bus.src2_writedata, 0);
    endtask

    task automatic drive_start(input int a1, input int a2);
        @(posedge clk);
        #1;
        start              = 1'b1;
        src1_start_address = AW'(a1);
        src2_start_address = AW'(a2);
        src1_count         = (AW+1)'(w1_q.size());
        src2_count         = (AW+1)'(w2_q.size());
        @(posedge clk);
        #1;
        // Scramble the request ports so anything not latched shows up.
        start              = 1'b0;
        src1_start_address = 12'h555;
        src2_start_address = 12'haaa;
        src1_count         = 13'd3;
        src2_count         = 13'd5;
    endtask

    task automatic run_load(input int a1, input int a2, input int trailer, input bit gaps,
                            input bit corrupt, input bit exp_err, input int exp_lat);
        int n;
        for (int i = 0; i < w1_q.size(); i++) begin
            push_exp(1, (a1 + i) % 4096, int'(w1_q[i]));
            stream_q.push_back(w1_q[i]);
        end
        for (int i = 0; i < w2_q.size(); i++) begin
            push_exp(2, (a2 + i) % 4096, int'(w2_q[i]));
            stream_q.push_back(w2_q[i]);
        end
        push_exp(3, int'(exp_err), int'(!exp_err));
        stream_q.push_back(DW'(trailer));
        gap_mode = gaps;
        drive_start(a1, a2);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (done) break;
            if (n == 1) check("busy_in_load", busy, 1);
            start      = gaps && (n == 3 || n == 12);
            corrupt_en = corrupt && (n == 6);
            if (n > 400) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
                break;
            end
        end
        start      = 1'b0;
        corrupt_en = 1'b0;
        gap_mode   = 1'b0;
        if (exp_lat > 0) check("done_latency", n, exp_lat);
        check("busy_at_done", busy, 0);
        if (!corrupt) begin
            for (int i = 0; i < w1_q.size(); i++) check("ram1_word", mem1[(a1 + i) % 4096], w1_q[i]);
            for (int i = 0; i < w2_q.size(); i++) check("ram2_word", mem2[(a2 + i) % 4096], w2_q[i]);
        end
        repeat (3) @(negedge clk);
        check("error_held", error, exp_err);
        check("done_one_cycle", done, 0);
        check("layer_start_one_cycle", layer_start, 0);
    endtask

    initial begin
        int seen;
        reset              = 1'b1;
        start              = 1'b0;
        src1_start_address = '0;
        src2_start_address = '0;
        src1_count         = '0;
        src2_count         = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("por");

        // Basic load, good checksum: 1+2+3+4+10+20 = 40.
        w1_q = '{16'd1, 16'd2, 16'd3, 16'd4};
        w2_q = '{16'd10, 16'd20};
        run_load(0, 27, 40, 1'b0, 1'b0, 1'b0, 17);

        // Same stream, wrong trailer.
        run_load(0, 27, 41, 1'b0, 1'b0, 1'b1, 17);

        // Wrapping region, empty weight region: 5+6+7+8 = 26.
        w1_q = '{16'd5, 16'd6, 16'd7, 16'd8};
        w2_q.delete();
        run_load(4094, 100, 26, 1'b0, 1'b0, 1'b0, 12);

        // Stream with random gaps and start pulses while busy.
        w1_q = '{16'd1, 16'd2, 16'd3, 16'd4};
        w2_q = '{16'd10, 16'd20};
        run_load(0, 27, 40, 1'b1, 1'b0, 1'b0, 0);

        // RAM1[2] overwritten after it was loaded: readback sum no longer matches.
        run_load(0, 27, 40, 1'b0, 1'b1, 1'b1, 17);
        check("ram1_corrupted", mem1[CORRUPT_ADDR], CORRUPT_DATA);

        // Reset after two image writes.
        w1_q = '{16'd7, 16'd9, 16'd11, 16'd13};
        push_exp(1, 0, 7);
        push_exp(1, 1, 9);
        stream_q = '{16'd7, 16'd9, 16'd11, 16'd13, 16'd10, 16'd20, 16'd60};
        drive_start(0, 27);
        seen = 0;
        for (int i = 0; i < 50 && seen < 2; i++) begin
            @(negedge clk);
            if (bus.src1_write_en) seen++;
        end
        check("reset_writes_before", seen, 2);
        stream_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        check("rst_ram1_0", mem1[0], 7);
        check("rst_ram1_1", mem1[1], 9);
        check("rst_ram1_2_kept", mem1[2], CORRUPT_DATA);

        // Fresh load after the aborted one.
        w1_q = '{16'd1, 16'd2, 16'd3, 16'd4};
        w2_q = '{16'd10, 16'd20};
        run_load(0, 27, 40, 1'b0, 1'b0, 1'b0, 17);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
